// File: rtl/bvule_bvor_skolem_serial_pkg.sv
// Shared definitions for the bit-serial Skolem witness generators.
// Holds the FSM state type, variant opcodes and the witness mask builder.
package bvskolem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Reserved selectors for sibling constraint variants sharing this scanner.
  localparam logic [1:0] OP_BVULE_BVOR  = 2'd0;
  localparam logic [1:0] OP_BVUGE_BVOR  = 2'd1;
  localparam logic [1:0] OP_BVULE_BVAND = 2'd2;

  localparam int MAX_W = 64;

  // Keeps t above position p, clears bit p and fills every bit below p with ones.
  function automatic logic [MAX_W-1:0] build_witness(input logic [MAX_W-1:0] t, input int p);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int k = 0; k < MAX_W; k++) begin
      if (k > p)       r[k] = t[k];
      else if (k == p) r[k] = 1'b0;
      else             r[k] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bvule_bvor_skolem_serial_bit_scan.sv
// MSB-first scanner: walks s/t one bit per cycle, tracking the first violation
// and the lowest t=1/s=0 position seen before it.
module bvskolem_bit_scan #(
  parameter int W     = 8,
  parameter int IDX_W = $clog2(W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_en,
  input  logic [W-1:0]     i_s,
  input  logic [W-1:0]     i_t,
  output logic [IDX_W-1:0] o_p,
  output logic             o_viol,
  output logic             o_candVld,
  output logic             o_last
);

  logic [IDX_W-1:0] r_i;
  logic [IDX_W-1:0] r_p;
  logic             r_viol;
  logic             r_candVld;
  logic [W-1:0]     w_sel;
  logic             w_sBit;
  logic             w_tBit;

  assign w_sel  = W'(1) << r_i;
  assign w_sBit = |(i_s & w_sel);
  assign w_tBit = |(i_t & w_sel);

  // After a violation the candidate is frozen; later bits cannot change the witness.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i       <= '0;
      r_p       <= '0;
      r_viol    <= 1'b0;
      r_candVld <= 1'b0;
    end else if (i_start) begin
      r_i       <= IDX_W'(W - 1);
      r_p       <= '0;
      r_viol    <= 1'b0;
      r_candVld <= 1'b0;
    end else if (i_en) begin
      if (!r_viol) begin
        if (w_tBit && !w_sBit) begin
          r_candVld <= 1'b1;
          r_p       <= r_i;
        end else if (w_sBit && !w_tBit) begin
          r_viol <= 1'b1;
        end
      end
      if (r_i != '0) r_i <= r_i - IDX_W'(1);
    end
  end

  assign o_p       = r_p;
  assign o_viol    = r_viol;
  assign o_candVld = r_candVld;
  assign o_last    = (r_i == '0);

endmodule

// File: rtl/bvule_bvor_skolem_serial.sv
// Bit-serial generator of the maximal x with (x | s) <=u t, plus invertibility flag.
// Valid/ready on both sides; one operand pair in flight at a time.
module bvule_bvor_skolem_serial
  import bvskolem_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_s,
  input  logic [W-1:0] in_t,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_x,
  output logic         out_ic
);

  localparam int IDX_W = $clog2(W) + 1;

  state_t           r_state;
  state_t           w_nextState;
  logic [W-1:0]     r_s;
  logic [W-1:0]     r_t;
  logic [W-1:0]     r_x;
  logic             r_ic;
  logic             r_outValid;
  logic             w_accept;
  logic             w_scanEn;
  logic             w_last;
  logic             w_viol;
  logic             w_candVld;
  logic [IDX_W-1:0] w_p;
  logic [W-1:0]     w_xWit;
  logic [W-1:0]     w_xNext;
  logic             w_icNext;

  bvskolem_bit_scan #(.W(W), .IDX_W(IDX_W)) u_scan (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_accept),
    .i_en     (w_scanEn),
    .i_s      (r_s),
    .i_t      (r_t),
    .o_p      (w_p),
    .o_viol   (w_viol),
    .o_candVld(w_candVld),
    .o_last   (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    w_scanEn    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_nextState = SCAN;
      end
      SCAN: begin
        w_scanEn = 1'b1;
        if (w_last) w_nextState = DONE;
      end
      DONE: begin
        if (r_outValid && out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_xWit   = W'(build_witness(MAX_W'(r_t), int'(w_p)));

  always_comb begin
    w_xNext  = '0;
    w_icNext = 1'b0;
    if (!w_viol) begin
      w_xNext  = r_t;
      w_icNext = 1'b1;
    end else if (w_candVld) begin
      w_xNext  = w_xWit;
      w_icNext = 1'b1;
    end
  end

  // The first DONE cycle captures the scanner verdict; later DONE cycles just hold it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s        <= '0;
      r_t        <= '0;
      r_x        <= '0;
      r_ic       <= 1'b0;
      r_outValid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s <= in_s;
        r_t <= in_t;
      end
      if (r_state == DONE && !r_outValid) begin
        r_x        <= w_xNext;
        r_ic       <= w_icNext;
        r_outValid <= 1'b1;
      end else if (r_state == DONE && out_ready) begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign out_valid = r_outValid;
  assign out_x     = r_x;
  assign out_ic    = r_ic;

endmodule

// File: tb/tb_bvule_bvor_skolem_serial.sv
// Self-checking bench for bvule_bvor_skolem_serial at W=8 and W=1.
// Expected witnesses come from a brute-force search for the largest valid x.
module tb_bvule_bvor_skolem_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       inValid8, inReady8, outValid8, outReady8, outIc8;
  logic [7:0] inS8, inT8, outX8;
  logic       inValid1, inReady1, outValid1, outReady1, outIc1;
  logic [0:0] inS1, inT1, outX1;
  int         nTests = 0;
  int         nFail  = 0;

  always #5 clk = ~clk;

  bvule_bvor_skolem_serial #(.W(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(inValid8), .in_ready(inReady8), .in_s(inS8), .in_t(inT8),
    .out_valid(outValid8), .out_ready(outReady8), .out_x(outX8), .out_ic(outIc8)
  );

  bvule_bvor_skolem_serial #(.W(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(inValid1), .in_ready(inReady1), .in_s(inS1), .in_t(inT1),
    .out_valid(outValid1), .out_ready(outReady1), .out_x(outX1), .out_ic(outIc1)
  );

  // Largest x in [0, 2^w) with (x | s) <= t; none exists exactly when s > t.
  function automatic int maxWitness(input int w, input int s, input int t, output bit ic);
    for (int x = (1 << w) - 1; x >= 0; x--) begin
      if ((x | s) <= t) begin
        ic = 1'b1;
        return x;
      end
    end
    ic = 1'b0;
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus8(input logic [7:0] s, input logic [7:0] t,
                                input int holdCycles, input bit preReady);
    int         n;
    int         expX;
    bit         expIc;
    logic [7:0] heldX;
    logic       heldIc;
    expX = maxWitness(8, int'(s), int'(t), expIc);
    n = 0;
    while (!inReady8 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("w8 in_ready before accept", 32'(inReady8), 32'd1);
    inValid8 = 1'b1;
    inS8 = s;
    inT8 = t;
    @(posedge clk); #1;
    inValid8 = 1'b0;
    inS8 = 8'($urandom);
    inT8 = 8'($urandom);
    if (preReady) outReady8 = 1'b1;
    n = 0;
    while (!outValid8 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("w8 latency", 32'(n), 32'd9);
    checkOutput("w8 out_x", 32'(outX8), 32'(expX));
    checkOutput("w8 out_ic", 32'(outIc8), 32'(expIc));
    heldX = outX8;
    heldIc = outIc8;
    if (!preReady) begin
      for (int h = 0; h < holdCycles; h++) begin
        inValid8 = 1'b1;
        inS8 = 8'($urandom);
        inT8 = 8'($urandom);
        @(posedge clk); #1;
        inValid8 = 1'b0;
        checkOutput("w8 hold out_valid", 32'(outValid8), 32'd1);
        checkOutput("w8 hold out_x", 32'(outX8), 32'(heldX));
        checkOutput("w8 hold out_ic", 32'(outIc8), 32'(heldIc));
        checkOutput("w8 hold in_ready", 32'(inReady8), 32'd0);
      end
      outReady8 = 1'b1;
    end
    @(posedge clk); #1;
    outReady8 = 1'b0;
    checkOutput("w8 out_valid after handshake", 32'(outValid8), 32'd0);
    checkOutput("w8 in_ready after handshake", 32'(inReady8), 32'd1);
  endtask

  task automatic applyStimulus1(input logic s, input logic t);
    int n;
    int expX;
    bit expIc;
    expX = maxWitness(1, int'(s), int'(t), expIc);
    n = 0;
    while (!inReady1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    inValid1 = 1'b1;
    inS1 = s;
    inT1 = t;
    @(posedge clk); #1;
    inValid1 = 1'b0;
    n = 0;
    while (!outValid1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("w1 latency", 32'(n), 32'd2);
    checkOutput("w1 out_x", 32'(outX1), 32'(expX));
    checkOutput("w1 out_ic", 32'(outIc1), 32'(expIc));
    outReady1 = 1'b1;
    @(posedge clk); #1;
    outReady1 = 1'b0;
    checkOutput("w1 in_ready after handshake", 32'(inReady1), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    inValid8 = 1'b0; outReady8 = 1'b0; inS8 = '0; inT8 = '0;
    inValid1 = 1'b0; outReady1 = 1'b0; inS1 = '0; inT1 = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", 32'(inReady8), 32'd1);
    checkOutput("reset out_valid", 32'(outValid8), 32'd0);
    checkOutput("reset out_x", 32'(outX8), 32'd0);
    checkOutput("reset out_ic", 32'(outIc8), 32'd0);
    checkOutput("reset w1 in_ready", 32'(inReady1), 32'd1);
    rst = 1'b0;

    applyStimulus8(8'h00, 8'hA5, 0, 1'b0);
    applyStimulus8(8'h12, 8'h31, 0, 1'b0);
    applyStimulus8(8'h80, 8'h7F, 0, 1'b0);
    applyStimulus8(8'h0F, 8'h0F, 0, 1'b1);
    applyStimulus8(8'h5A, 8'h7E, 3, 1'b0);

    repeat (12) begin
      @(posedge clk); #1;
    end
    checkOutput("ignored in_valid not queued", 32'(outValid8), 32'd0);

    // Abort a transaction while the scanner is on bit 4.
    inValid8 = 1'b1;
    inS8 = 8'h03;
    inT8 = 8'h05;
    @(posedge clk); #1;
    inValid8 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("mid-scan reset in_ready", 32'(inReady8), 32'd1);
    checkOutput("mid-scan reset out_valid", 32'(outValid8), 32'd0);
    checkOutput("mid-scan reset out_x", 32'(outX8), 32'd0);
    checkOutput("mid-scan reset out_ic", 32'(outIc8), 32'd0);
    repeat (12) begin
      @(posedge clk); #1;
    end
    checkOutput("no partial result after reset", 32'(outValid8), 32'd0);

    applyStimulus8(8'h01, 8'h02, 0, 1'b0);
    applyStimulus8(8'h00, 8'hFF, 1, 1'b0);
    applyStimulus8(8'h7F, 8'h80, 0, 1'b0);

    for (int v = 0; v < 4; v++) begin
      applyStimulus1(1'(v >> 1), 1'(v));
    end

    for (int r = 0; r < 200; r++) begin
      applyStimulus8(8'($urandom), 8'($urandom), int'($urandom_range(2, 0)), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
